ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_if.sv | 12 +
 rtl/ifu_npc.sv | 27 ++
 rtl/ifu.sv | 150 +++++++++++++++
 tb/tb_ifu.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared IFU definitions: bus widths, reset vector, exception/stall bit indices, FSM encoding.
package ifu_pkg;

    localparam int PC_WD        = 32;
    localparam int EXC_WD       = 32;
    localparam int IC_TO_ID_WD  = 65;
    localparam int STALLBUS_WD  = 6;
    localparam int STALL_IF_BIT = 1;
    localparam int STALL_ID_BIT = 2;
    localparam int EXC_ADEL_BIT = 16;

    localparam logic [PC_WD-1:0] RESET_VECTOR = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_if.sv
// Instruction-memory handshake between the IFU (master) and the memory side (slave).
interface ifu_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    modport master (output inst_req, inst_addr, input inst_addr_ok, inst_data_ok);
    modport slave  (input inst_req, inst_addr, output inst_addr_ok, inst_data_ok);

endinterface

// File: rtl/ifu_npc.sv
// Next-PC priority mux: flush target, then branch target, then pending redirect, then pc+4.
module ifu_npc
    import ifu_pkg::*;
(
    input  logic             flush_i,
    input  logic [PC_WD-1:0] new_pc_i,
    input  logic             br_e_i,
    input  logic [PC_WD-1:0] br_addr_i,
    input  logic             pend_i,
    input  logic [PC_WD-1:0] pending_pc_i,
    input  logic [PC_WD-1:0] pc_i,
    output logic [PC_WD-1:0] npc_o
);

    always_comb begin
        if (flush_i) begin
            npc_o = new_pc_i;
        end else if (br_e_i) begin
            npc_o = br_addr_i;
        end else if (pend_i) begin
            npc_o = pending_pc_i;
        end else begin
            npc_o = pc_i + 32'd4;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: IDLE/REQ/WAIT fetch FSM, PC register and registered IC->ID bus.
// Optional build macro IFU_ADEL_CHECK_EN raises a fetch AdEL instead of fetching a misaligned PC.
module ifu
    import ifu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic [PC_WD-1:0]       new_pc_i,
    input  logic [STALLBUS_WD-1:0] stall_i,
    input  logic                   br_e_i,
    input  logic [PC_WD-1:0]       br_addr_i,
    output logic                   stallreq_o,
    output logic [IC_TO_ID_WD-1:0] ic_to_id_bus_o,
    ifu_if.master                  mem
);

    ifu_state_e             state_q, state_d;
    logic [PC_WD-1:0]       pc_q, pc_d, npc;
    logic [PC_WD-1:0]       pendingPc_q, pendingPc_d;
    logic                   pend_q, pend_d;
    logic [IC_TO_ID_WD-1:0] bus_q, bus_d;
    logic [EXC_WD-1:0]      excVal;
    logic                   pcEn, fetchDone, adelFetch, instReq, stallReq;
    logic                   redirect, ifStall, idStall;
    logic                   unusedStall;

    assign redirect    = flush_i | br_e_i;
    assign ifStall     = stall_i[STALL_IF_BIT];
    assign idStall     = stall_i[STALL_ID_BIT];
    assign unusedStall = ^{stall_i[STALLBUS_WD-1:STALL_ID_BIT+1], stall_i[0]};

`ifdef IFU_ADEL_CHECK_EN
    assign adelFetch = (state_q == REQ) && (pc_q[1:0] != 2'b00);
    always_comb begin
        excVal               = '0;
        excVal[EXC_ADEL_BIT] = adelFetch;
    end
`else
    assign adelFetch = 1'b0;
    assign excVal    = '0;
`endif

    ifu_npc u_npc (
        .flush_i     (flush_i),
        .new_pc_i    (new_pc_i),
        .br_e_i      (br_e_i),
        .br_addr_i   (br_addr_i),
        .pend_i      (pend_q),
        .pending_pc_i(pendingPc_q),
        .pc_i        (pc_q),
        .npc_o       (npc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_VECTOR;
            pend_q      <= 1'b0;
            pendingPc_q <= '0;
            bus_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pendingPc_q <= pendingPc_d;
            bus_q       <= bus_d;
        end
    end

    // A redirect that lands after the address was accepted leaves a stale response in flight;
    // pend marks it so it is dropped on arrival instead of reaching ID.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pendingPc_d = pendingPc_q;
        pcEn        = 1'b0;
        fetchDone   = 1'b0;
        instReq     = 1'b0;
        stallReq    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                pcEn    = redirect;
            end
            REQ: begin
                if (adelFetch) begin
                    if (redirect) begin
                        pcEn = 1'b1;
                    end else if (!ifStall) begin
                        pcEn      = 1'b1;
                        fetchDone = 1'b1;
                    end
                end else begin
                    instReq  = 1'b1;
                    stallReq = 1'b1;
                    pcEn     = redirect;
                    if (mem.inst_addr_ok) begin
                        state_d = WAIT;
                        if (redirect) begin
                            pend_d      = 1'b1;
                            pendingPc_d = npc;
                        end
                    end
                end
            end
            WAIT: begin
                stallReq = !mem.inst_data_ok;
                if (mem.inst_data_ok) begin
                    if (pend_q || redirect) begin
                        state_d = REQ;
                        pend_d  = 1'b0;
                        pcEn    = 1'b1;
                    end else if (!ifStall) begin
                        state_d   = REQ;
                        pcEn      = 1'b1;
                        fetchDone = 1'b1;
                    end
                end else if (redirect) begin
                    pend_d      = 1'b1;
                    pendingPc_d = npc;
                    pcEn        = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc_d = pcEn ? npc : pc_q;

    // Flush beats any stall; an IF stall either bubbles ID or, when ID is also held, freezes the bus.
    always_comb begin
        bus_d = '0;
        if (flush_i) begin
            bus_d = '0;
        end else if (br_e_i && !ifStall) begin
            bus_d = '0;
        end else if (ifStall) begin
            bus_d = idStall ? bus_q : '0;
        end else if (fetchDone) begin
            bus_d = {excVal, 1'b1, pc_q};
        end
    end

    assign mem.inst_req   = instReq;
    assign mem.inst_addr  = pc_q;
    assign stallreq_o     = stallReq;
    assign ic_to_id_bus_o = bus_q;

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu: fetch, hold/bubble, redirects, wrap, reset-in-WAIT, AdEL.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] new_pc;
    logic [5:0]  stall;
    logic        br_e;
    logic [31:0] br_addr;
    logic        stallreq;
    logic [64:0] bus;

    int total = 0;
    int bad   = 0;

    ifu_if mem ();

    ifu dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .new_pc_i      (new_pc),
        .stall_i       (stall),
        .br_e_i        (br_e),
        .br_addr_i     (br_addr),
        .stallreq_o    (stallreq),
        .ic_to_id_bus_o(bus),
        .mem           (mem)
    );

    always #5 clk = ~clk;

    function automatic logic [64:0] ent(input logic [31:0] exc, input logic [31:0] pc);
        return {exc, 1'b1, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        flush   = 1'b0;
        new_pc  = '0;
        stall   = '0;
        br_e    = 1'b0;
        br_addr = '0;
        mem.inst_addr_ok = 1'b0;
        mem.inst_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        tick();
        tick();
        total++; if (mem.inst_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b want 0", mem.inst_req); end
        total++; if (stallreq !== 1'b0) begin bad++; $display("[TB] FAIL reset_stallreq: got %b want 0", stallreq); end
        total++; if (bus !== 65'd0) begin bad++; $display("[TB] FAIL reset_bus: got %h want 0", bus); end
        total++; if (mem.inst_addr !== 32'hBFC00000) begin bad++; $display("[TB] FAIL reset_pc: got %h want bfc00000", mem.inst_addr); end
    endtask

    task automatic test_fetch();
        rst = 1'b0;
        tick();
        total++; if (mem.inst_req !== 1'b1 || mem.inst_addr !== 32'hBFC00000) begin bad++; $display("[TB] FAIL fetch_req0: got req=%b addr=%h want req=1 addr=bfc00000", mem.inst_req, mem.inst_addr); end
        total++; if (stallreq !== 1'b1) begin bad++; $display("[TB] FAIL fetch_stallreq_req: got %b want 1", stallreq); end
        mem.inst_addr_ok = 1'b1;
        tick();
        mem.inst_addr_ok = 1'b0;
        total++; if (mem.inst_req !== 1'b0 || stallreq !== 1'b1) begin bad++; $display("[TB] FAIL fetch_wait: got req=%b stallreq=%b want req=0 stallreq=1", mem.inst_req, stallreq); end
        mem.inst_data_ok = 1'b1;
        #1;
        total++; if (stallreq !== 1'b0) begin bad++; $display("[TB] FAIL fetch_stallreq_data: got %b want 0", stallreq); end
        tick();
        mem.inst_data_ok = 1'b0;
        total++; if (bus !== ent(32'h0, 32'hBFC00000)) begin bad++; $display("[TB] FAIL fetch_bus: got %h want %h", bus, ent(32'h0, 32'hBFC00000)); end
        total++; if (mem.inst_req !== 1'b1 || mem.inst_addr !== 32'hBFC00004) begin bad++; $display("[TB] FAIL fetch_req1: got req=%b addr=%h want req=1 addr=bfc00004", mem.inst_req, mem.inst_addr); end
    endtask

    task automatic test_hold();
        stall = 6'b000110;
        tick();
        total++; if (bus !== ent(32'h0, 32'hBFC00000)) begin bad++; $display("[TB] FAIL hold_bus: got %h want %h", bus, ent(32'h0, 32'hBFC00000)); end
        stall = 6'b000000;
        tick();
        total++; if (bus !== 65'd0) begin bad++; $display("[TB] FAIL hold_release_bus: got %h want 0", bus); end
        total++; if (mem.inst_addr !== 32'hBFC00004) begin bad++; $display("[TB] FAIL hold_pc: got %h want bfc00004", mem.inst_addr); end
    endtask

    task automatic test_branch_wait();
        mem.inst_addr_ok = 1'b1;
        tick();
        mem.inst_addr_ok = 1'b0;
        br_e    = 1'b1;
        br_addr = 32'h80001000;
        tick();
        br_e = 1'b0;
        total++; if (mem.inst_req !== 1'b0) begin bad++; $display("[TB] FAIL br_still_wait: got req=%b want 0", mem.inst_req); end
        mem.inst_data_ok = 1'b1;
        tick();
        mem.inst_data_ok = 1'b0;
        total++; if (bus !== 65'd0) begin bad++; $display("[TB] FAIL br_discard_bus: got %h want 0", bus); end
        total++; if (mem.inst_req !== 1'b1 || mem.inst_addr !== 32'h80001000) begin bad++; $display("[TB] FAIL br_next_req: got req=%b addr=%h want req=1 addr=80001000", mem.inst_req, mem.inst_addr); end
    endtask

    task automatic test_flush();
        flush   = 1'b1;
        new_pc  = 32'hBFC00380;
        br_e    = 1'b1;
        br_addr = 32'h80002000;
        tick();
        flush = 1'b0;
        br_e  = 1'b0;
        total++; if (mem.inst_req !== 1'b1 || mem.inst_addr !== 32'hBFC00380) begin bad++; $display("[TB] FAIL flush_req: got req=%b addr=%h want req=1 addr=bfc00380", mem.inst_req, mem.inst_addr); end
        total++; if (bus !== 65'd0) begin bad++; $display("[TB] FAIL flush_bus: got %h want 0", bus); end
        mem.inst_addr_ok = 1'b1;
        tick();
        mem.inst_addr_ok = 1'b0;
        mem.inst_data_ok = 1'b1;
        tick();
        mem.inst_data_ok = 1'b0;
        total++; if (bus !== ent(32'h0, 32'hBFC00380)) begin bad++; $display("[TB] FAIL flush_fetch_bus: got %h want %h", bus, ent(32'h0, 32'hBFC00380)); end
    endtask

    task automatic test_stall_bubble();
        mem.inst_addr_ok = 1'b1;
        tick();
        mem.inst_addr_ok = 1'b0;
        mem.inst_data_ok = 1'b1;
        stall = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus !== 65'd0) begin bad++; $display("[TB] FAIL bubble_bus_%0d: got %h want 0", i, bus); end
            total++; if (mem.inst_addr !== 32'hBFC00384 || mem.inst_req !== 1'b0) begin bad++; $display("[TB] FAIL bubble_pc_%0d: got addr=%h req=%b want addr=bfc00384 req=0", i, mem.inst_addr, mem.inst_req); end
        end
        stall = 6'b000000;
        tick();
        mem.inst_data_ok = 1'b0;
        total++; if (bus !== ent(32'h0, 32'hBFC00384)) begin bad++; $display("[TB] FAIL bubble_resend_bus: got %h want %h", bus, ent(32'h0, 32'hBFC00384)); end
        total++; if (mem.inst_addr !== 32'hBFC00388) begin bad++; $display("[TB] FAIL bubble_next_pc: got %h want bfc00388", mem.inst_addr); end
    endtask

    task automatic test_wrap();
        br_e    = 1'b1;
        br_addr = 32'hFFFFFFFC;
        tick();
        br_e = 1'b0;
        mem.inst_addr_ok = 1'b1;
        tick();
        mem.inst_addr_ok = 1'b0;
        mem.inst_data_ok = 1'b1;
        tick();
        mem.inst_data_ok = 1'b0;
        total++; if (bus !== ent(32'h0, 32'hFFFFFFFC)) begin bad++; $display("[TB] FAIL wrap_bus: got %h want %h", bus, ent(32'h0, 32'hFFFFFFFC)); end
        total++; if (mem.inst_addr !== 32'h00000000) begin bad++; $display("[TB] FAIL wrap_pc: got %h want 00000000", mem.inst_addr); end
    endtask

    task automatic test_misaligned();
        br_e    = 1'b1;
        br_addr = 32'h80000002;
        tick();
        br_e = 1'b0;
`ifdef IFU_ADEL_CHECK_EN
        total++; if (mem.inst_req !== 1'b0) begin bad++; $display("[TB] FAIL adel_noreq: got %b want 0", mem.inst_req); end
        tick();
        total++; if (bus !== ent(32'h00010000, 32'h80000002)) begin bad++; $display("[TB] FAIL adel_bus: got %h want %h", bus, ent(32'h00010000, 32'h80000002)); end
`else
        total++; if (mem.inst_req !== 1'b1 || mem.inst_addr !== 32'h80000002) begin bad++; $display("[TB] FAIL misaligned_req: got req=%b addr=%h want req=1 addr=80000002", mem.inst_req, mem.inst_addr); end
        mem.inst_addr_ok = 1'b1;
        tick();
        mem.inst_addr_ok = 1'b0;
        mem.inst_data_ok = 1'b1;
        tick();
        mem.inst_data_ok = 1'b0;
        total++; if (bus !== ent(32'h0, 32'h80000002)) begin bad++; $display("[TB] FAIL misaligned_bus: got %h want %h", bus, ent(32'h0, 32'h80000002)); end
`endif
    endtask

    task automatic test_reset_wait();
        idleInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        mem.inst_addr_ok = 1'b1;
        tick();
        mem.inst_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem.inst_data_ok = 1'b1;
        tick();
        tick();
        mem.inst_data_ok = 1'b0;
        total++; if (bus !== 65'd0) begin bad++; $display("[TB] FAIL rstwait_bus: got %h want 0", bus); end
        total++; if (mem.inst_req !== 1'b1 || mem.inst_addr !== 32'hBFC00000) begin bad++; $display("[TB] FAIL rstwait_req: got req=%b addr=%h want req=1 addr=bfc00000", mem.inst_req, mem.inst_addr); end
    endtask

    initial begin
        $display("[TB] starting ifu bench");
        test_reset();
        test_fetch();
        test_hold();
        test_branch_wait();
        test_flush();
        test_stall_bubble();
        test_wrap();
        test_misaligned();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
